// File: rtl/ram_programmer.sv
// ram_programmer
// Program memory for the 4-bit-address bus computer: a DEPTH x DATA_W RAM
// behind a memory address register (MAR) on the shared bus, plus the
// front-panel programming path.  At the end of a programming session it
// pulses the program counter's load interface with the entry address.
//
// Ports
//   CLK, RESET        clock (rising edge), synchronous active-high reset
//   en                run-mode bus operation enable
//   bus_in            shared bus value
//   bus_out           registered RAM read data / programming readback
//   mar_we            latch bus_in[ADDR_W-1:0] into MAR
//   ram_we            write bus_in to RAM[MAR]
//   ram_oe            read RAM[MAR] to bus_out
//   mar               current MAR
//   prog_mode         level, 1 = programming session
//   prog_addr         programming address / entry address
//   prog_data         programming data
//   prog_strobe       write request, rising-edge sensitive
//   prog_busy         word write in progress
//   prog_err          sticky overrun flag (cleared on session entry)
//   word_count        words written this session, saturates at DEPTH
//   pc_load, pc_addr  one-cycle PC load pulse and its value
//   dbg_state         current FSM state encoding
//
// Handshake: a programming word is requested by a 0->1 transition of
// prog_strobe while idle in program mode; the word occupies the block for
// two cycles (prog_busy=1) and any further strobe rise inside that window
// is an overrun: the word is dropped and prog_err is set.
module ram_programmer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              en,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    input  logic              mar_we,
    input  logic              ram_we,
    input  logic              ram_oe,
    output logic [ADDR_W-1:0] mar,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_strobe,
    output logic              prog_busy,
    output logic              prog_err,
    output logic [ADDR_W:0]   word_count,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        P_IDLE  = 3'd1,
        P_WRITE = 3'd2,
        P_READ  = 3'd3,
        P_LOAD  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              strobe_q;
    logic              strobe_rise;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [ADDR_W-1:0] pc_addr_q;
    logic              run_active;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    assign strobe_rise = prog_strobe & ~strobe_q;
    // prog_mode wins over en: the cycle that starts a session does no bus op.
    assign run_active  = (state == RUN) && !prog_mode && en;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (prog_mode) state_nx = P_IDLE;
            P_IDLE:  begin
                if (strobe_rise)     state_nx = P_WRITE;
                else if (!prog_mode) state_nx = P_LOAD;
            end
            P_WRITE: state_nx = P_READ;
            P_READ:  state_nx = P_IDLE;
            P_LOAD:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign dbg_state = state;
    assign prog_busy = (state == P_WRITE) || (state == P_READ);
    assign pc_load   = (state == P_LOAD);
    // During the load pulse the PC sees prog_addr directly; afterwards the
    // sampled value is held so pc_addr stays stable.
    assign pc_addr   = pc_load ? prog_addr : pc_addr_q;

    // ---------------- RAM write port ----------------
    assign mem_we = (run_active && ram_we) || (state == P_WRITE);
    assign mem_wa = (state == P_WRITE) ? cap_addr : mar;
    assign mem_wd = (state == P_WRITE) ? cap_data : bus_in;

    // RAM has no reset, but a write coinciding with RESET is suppressed so an
    // interrupted programming word never lands.
    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) mem[mem_wa] <= mem_wd;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            strobe_q   <= 1'b0;
            mar        <= '0;
            bus_out    <= '0;
            prog_err   <= 1'b0;
            word_count <= '0;
            pc_addr_q  <= '0;
            cap_addr   <= '0;
            cap_data   <= '0;
        end else begin
            strobe_q <= prog_strobe;
            case (state)
                RUN: begin
                    if (prog_mode) begin
                        prog_err   <= 1'b0;
                        word_count <= '0;
                    end else if (en) begin
                        // Reads and writes use the MAR value before this edge.
                        if (mar_we) mar <= bus_in[ADDR_W-1:0];
                        if (ram_oe) bus_out <= mem[mar];
                    end
                end
                P_IDLE: begin
                    if (strobe_rise) begin
                        cap_addr <= prog_addr;
                        cap_data <= prog_data;
                    end
                end
                P_WRITE: begin
                    if (strobe_rise) prog_err <= 1'b1;
                end
                P_READ: begin
                    if (strobe_rise) prog_err <= 1'b1;
                    bus_out <= mem[cap_addr];
                    if (word_count != (ADDR_W + 1)'(DEPTH))
                        word_count <= word_count + 1'b1;
                end
                P_LOAD: begin
                    mar       <= prog_addr;
                    pc_addr_q <= prog_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_programmer.sv
// Self-checking bench for ram_programmer: directed run-mode and programming
// scenarios plus randomized run-mode traffic, checked against an array model
// of the RAM and MAR.
module tb_ram_programmer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic              en, mar_we, ram_we, ram_oe;
    logic [DATA_W-1:0] bus_in, bus_out;
    logic [ADDR_W-1:0] mar;
    logic              prog_mode, prog_strobe;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_busy, prog_err, pc_load;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W-1:0] pc_addr;
    logic [2:0]        dbg_state;

    ram_programmer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .en(en), .bus_in(bus_in), .bus_out(bus_out),
        .mar_we(mar_we), .ram_we(ram_we), .ram_oe(ram_oe), .mar(mar),
        .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_strobe(prog_strobe), .prog_busy(prog_busy), .prog_err(prog_err),
        .word_count(word_count), .pc_load(pc_load), .pc_addr(pc_addr),
        .dbg_state(dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [ADDR_W-1:0] mar_m;
    logic [DATA_W-1:0] bus_m;
    int                wc_m;
    logic [DATA_W-1:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input bit e, input bit mw, input bit rw, input bit oe,
                          input logic [DATA_W-1:0] b);
        logic [ADDR_W-1:0] old_mar;
        old_mar = mar_m;
        en = e; mar_we = mw; ram_we = rw; ram_oe = oe; bus_in = b;
        step();
        en = 0; mar_we = 0; ram_we = 0; ram_oe = 0;
        if (e) begin
            if (oe) bus_m = mem_m[old_mar];
            if (rw) mem_m[old_mar] = b;
            if (mw) mar_m = b[ADDR_W-1:0];
        end
        check("run_mar", 32'(mar), 32'(mar_m));
        check("run_bus_out", 32'(bus_out), 32'(bus_m));
    endtask

    task automatic run_read(input logic [ADDR_W-1:0] a);
        run_op(1, 1, 0, 0, DATA_W'(a));
        run_op(1, 0, 0, 1, DATA_W'($urandom));
    endtask

    task automatic enter_session();
        prog_mode = 1;
        step();
        wc_m = 0;
        check("entry_word_count", 32'(word_count), 0);
        check("entry_prog_err", 32'(prog_err), 0);
    endtask

    task automatic prog_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input int extra);
        prog_addr = a; prog_data = d; prog_strobe = 1;
        exp_q.push_back(d);
        step();
        check("busy_write", 32'(prog_busy), 1);
        prog_strobe = 0; prog_addr = ADDR_W'($urandom); prog_data = DATA_W'($urandom);
        step();
        check("busy_read", 32'(prog_busy), 1);
        step();
        mem_m[a] = d;
        if (wc_m < DEPTH) wc_m++;
        bus_m = exp_q.pop_front();
        check("readback", 32'(bus_out), 32'(bus_m));
        check("word_count", 32'(word_count), 32'(wc_m));
        check("busy_idle", 32'(prog_busy), 0);
        repeat (extra) step();
    endtask

    task automatic exit_session(input logic [ADDR_W-1:0] entry);
        prog_mode = 0; prog_addr = entry;
        step();
        check("pc_load_pulse", 32'(pc_load), 1);
        check("pc_addr", 32'(pc_addr), 32'(entry));
        step();
        mar_m = entry;
        check("pc_load_end", 32'(pc_load), 0);
        check("mar_entry", 32'(mar), 32'(entry));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ADDR_W-1:0] a1, a2;
        logic [DATA_W-1:0] d1, d2, old;

        en = 0; mar_we = 0; ram_we = 0; ram_oe = 0; bus_in = 0;
        prog_mode = 0; prog_strobe = 0; prog_addr = 0; prog_data = 0;
        mar_m = 0; bus_m = 0; wc_m = 0;

        repeat (2) step();
        check("rst_mar", 32'(mar), 0);
        check("rst_bus_out", 32'(bus_out), 0);
        check("rst_busy", 32'(prog_busy), 0);
        check("rst_err", 32'(prog_err), 0);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_pc_load", 32'(pc_load), 0);
        check("rst_pc_addr", 32'(pc_addr), 0);
        RESET = 0;

        // Run-mode write then read.
        run_op(1, 1, 0, 0, 8'h05);
        run_op(1, 0, 1, 0, 8'hA7);
        run_op(1, 0, 0, 1, 8'h00);
        check("dir_read_a7", 32'(bus_out), 32'h0A7);
        check("dir_mar_5", 32'(mar), 5);

        // mar_we + ram_we together: write uses old MAR (2).
        run_op(1, 1, 0, 0, 8'h02);
        run_op(1, 1, 1, 0, 8'h3C);
        check("dir_mar_c", 32'(mar), 32'hC);
        run_read(4'h2);
        check("dir_ram2_3c", 32'(bus_out), 32'h3C);

        // ram_we + ram_oe together returns pre-write data.
        run_op(1, 0, 1, 1, 8'h55);
        check("dir_prewrite", 32'(bus_out), 32'h3C);
        run_op(1, 0, 0, 1, 8'h00);

        // en=0 blocks all bus controls; bus_out holds.
        run_op(0, 1, 1, 1, 8'h99);
        run_read(4'h2);
        check("dir_en0_blocked", 32'(bus_out), 32'h55);

        // Directed programming session at 4-cycle spacing.
        enter_session();
        prog_word(4'h0, 8'h1E, 1);
        prog_word(4'h1, 8'h2F, 1);
        prog_word(4'h2, 8'hE0, 1);
        check("sess_word_count", 32'(word_count), 3);
        exit_session(4'h0);
        run_read(4'h0);
        run_read(4'h1);
        run_read(4'h2);

        // Saturation: 20 words at minimum spacing, random data.
        enter_session();
        for (int i = 0; i < 20; i++)
            prog_word(ADDR_W'(i % DEPTH), DATA_W'($urandom), 0);
        check("sat_word_count", 32'(word_count), DEPTH);
        check("sat_no_err", 32'(prog_err), 0);
        exit_session(ADDR_W'($urandom_range(0, DEPTH - 1)));

        // Randomized run-mode traffic against the model.
        for (int i = 0; i < 40; i++)
            run_op($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                   1'($urandom), DATA_W'($urandom));

        // Overrun: strobe edges two cycles apart.
        a1 = ADDR_W'($urandom_range(0, 7));
        a2 = ADDR_W'($urandom_range(8, 15));
        d1 = DATA_W'($urandom);
        d2 = ~mem_m[a2];
        enter_session();
        prog_addr = a1; prog_data = d1; prog_strobe = 1;
        step();
        prog_strobe = 0;
        step();
        prog_addr = a2; prog_data = d2; prog_strobe = 1;
        step();
        mem_m[a1] = d1; bus_m = d1;
        check("ovr_err", 32'(prog_err), 1);
        check("ovr_word_count", 32'(word_count), 1);
        check("ovr_readback", 32'(bus_out), 32'(d1));
        step();
        prog_strobe = 0;
        step();
        check("ovr_no_retrigger", 32'(word_count), 1);
        exit_session(a1);
        check("ovr_err_holds", 32'(prog_err), 1);
        run_read(a2);
        run_read(a1);

        // Held strobe: one write only; entry clears the overrun flag.
        a1 = ADDR_W'($urandom_range(0, DEPTH - 1));
        d1 = DATA_W'($urandom);
        enter_session();
        prog_addr = a1; prog_data = d1; prog_strobe = 1;
        repeat (10) step();
        prog_strobe = 0;
        step();
        mem_m[a1] = d1; bus_m = d1;
        check("held_word_count", 32'(word_count), 1);
        check("held_readback", 32'(bus_out), 32'(d1));
        exit_session(a1);
        run_read(a1);

        // RESET while in P_WRITE: write must not land, no PC load.
        a1 = ADDR_W'($urandom_range(0, DEPTH - 1));
        old = mem_m[a1];
        enter_session();
        prog_addr = a1; prog_data = ~old; prog_strobe = 1;
        step();
        check("rstw_busy_before", 32'(prog_busy), 1);
        RESET = 1; prog_strobe = 0; prog_mode = 0;
        step();
        RESET = 0;
        mar_m = 0; bus_m = 0;
        check("rstw_busy", 32'(prog_busy), 0);
        check("rstw_mar", 32'(mar), 0);
        check("rstw_bus_out", 32'(bus_out), 0);
        check("rstw_word_count", 32'(word_count), 0);
        check("rstw_err", 32'(prog_err), 0);
        for (int i = 0; i < 4; i++) begin
            check("rstw_pc_load", 32'(pc_load), 0);
            step();
        end
        run_read(a1);
        check("rstw_ram_kept", 32'(bus_out), 32'(old));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_programmer.md
# ram_programmer

Program memory for the 4-bit-address bus computer. It holds a 16×8 RAM behind a memory address register (MAR) on the shared bus, and owns the front-panel programming path. At the end of a programming session it drives the program counter's load interface (`pc_load`/`pc_addr`), so the PC starts from the programmed entry address. In run mode it answers bus reads and writes; in program mode it takes words from the programming port with a strobe handshake and reports overruns.

## Interface
- `DATA_W`, default 8: RAM word and bus width.
- `ADDR_W`, default 4: MAR/address width.
- `DEPTH`, default 16: number of RAM words (2^ADDR_W).

- `CLK`  in  1  clock, all state changes on rising edge.
- `RESET`  in  1  synchronous, active-high.
- `en`  in  1  run-mode bus operation enable.
- `bus_in`  in  DATA_W  shared bus value.
- `bus_out`  out  DATA_W  registered RAM read data / programming readback.
- `mar_we`  in  1  latch `bus_in[ADDR_W-1:0]` into MAR.
- `ram_we`  in  1  write `bus_in` to RAM[MAR].
- `ram_oe`  in  1  read RAM[MAR] to `bus_out`.
- `mar`  out  ADDR_W  current MAR (always visible).
- `prog_mode`  in  1  level: 1 = programming session.
- `prog_addr`  in  ADDR_W  programming address / entry address.
- `prog_data`  in  DATA_W  programming data.
- `prog_strobe`  in  1  write request, rising-edge sensitive.
- `prog_busy`  out  1  word write in progress.
- `prog_err`  out  1  sticky overrun flag.
- `word_count`  out  ADDR_W+1  words written this session, saturates at DEPTH.
- `pc_load`  out  1  one-cycle load pulse to PC.
- `pc_addr`  out  ADDR_W  PC load value, valid while `pc_load`=1.

## Operation
- States: RUN, P_IDLE, P_WRITE, P_READ, P_LOAD.
- RESET: state RUN; `mar`=0, `bus_out`=0, `prog_busy`=0, `prog_err`=0, `word_count`=0, `pc_load`=0, `pc_addr`=0; strobe edge register=0. RAM contents are not cleared.
- RUN, `en`=1:
  - `mar_we` sets MAR to `bus_in[3:0]`.
  - `ram_we` sets RAM[MAR] to `bus_in`.
  - `ram_oe` sets `bus_out` to RAM[MAR].
  - `mar_we` together with `ram_we`/`ram_oe`: the RAM access uses the old MAR.
  - `ram_we` together with `ram_oe`: `bus_out` gets the pre-write data.
- RUN, `en`=0: bus controls are ignored. `bus_out` holds its value.
- RUN with `prog_mode`=1 goes to P_IDLE (takes precedence over `en`). Entering P_IDLE from RUN clears `prog_err` and `word_count`.
- In all P_* states, `en`, `mar_we`, `ram_we` and `ram_oe` are ignored.
- P_IDLE:
  - A strobe rising edge (`prog_strobe`=1, previous sample 0) captures `prog_addr`/`prog_data` and goes to P_WRITE.
  - Holding the strobe high does not retrigger.
  - `prog_mode`=0 with no edge goes to P_LOAD.
- P_WRITE: `prog_busy`=1; RAM[captured addr] is written with captured data; go to P_READ.
- P_READ: `prog_busy`=1; `bus_out` is loaded with RAM[captured addr] as readback; `word_count` increments (saturating at 16); go to P_IDLE.
- A strobe rising edge seen in P_WRITE or P_READ sets `prog_err`=1. That word is dropped.
- `prog_mode` falling during P_WRITE/P_READ: the current word completes, then P_IDLE sees `prog_mode`=0 and goes to P_LOAD.
- P_LOAD: `pc_load`=1, `pc_addr` and `mar` are set to the `prog_addr` sampled in this state; go to RUN. `pc_load` is 0 in every other state.
- `prog_err` and `word_count` hold after the session ends until the next session starts or RESET.

## Timing
- MAR update: visible the cycle after the `mar_we` edge.
- RAM read: `bus_out` is valid 1 cycle after the `ram_oe` edge.
- Programming word: strobe edge at cycle N; capture and enter P_WRITE at N+1; RAM written at end of N+1; readback on `bus_out` and `word_count` incremented at N+3; `prog_busy` high during N+1..N+2.
- Minimum strobe-edge spacing is 3 cycles. Closer edges set `prog_err`.
- Session exit: `prog_mode` low at cycle M in P_IDLE; `pc_load` high for exactly cycle M+1..M+2 edge; RUN from M+2.
- RESET mid-session (any P_* state): next cycle is RUN with all outputs at reset values. A write in flight at P_WRITE with RESET asserted is not performed.

## Test plan
- Run-mode write/read: `en`=1; `mar_we` with `bus_in`=0x05; then `ram_we` with `bus_in`=0xA7; then `ram_oe` → `bus_out`=0xA7 one cycle after the `ram_oe` edge, `mar`=5.
- Simultaneous `mar_we`+`ram_we` with `bus_in`=0x3C, MAR=2 → RAM[2]=0x3C, `mar`=0xC.
- Programming session: `prog_mode`=1; strobe writes (0,0x1E), (1,0x2F), (2,0xE0) at 4-cycle spacing; `prog_mode`=0 with `prog_addr`=0 → readbacks 0x1E/0x2F/0xE0, `word_count`=3, `pc_load` pulse of 1 cycle with `pc_addr`=0, then run reads return the programmed data.
- Overrun: strobe edges 2 cycles apart → `prog_err`=1, `word_count`=1, only the first word is written. Next session entry clears `prog_err`.
- Held strobe: `prog_strobe` high for 10 cycles → exactly one write, `word_count`=1. Saturation: 20 writes → `word_count`=16.
- RESET asserted in P_WRITE → RAM word unchanged, state RUN, `prog_busy`=0, `pc_load` never pulses. `en`=0 in RUN blocks `ram_we`.
